// File: rtl/mips_cpu_hilo_pkg.sv
// Shared constants for the HI/LO multiply/divide unit: op codes, FSM states,
// data width and the divide-by-zero LO value.
package mips_cpu_hilo_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [3:0] OP_NOP   = 4'd0;
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MADDU = 4'd8;

  localparam logic [XLEN-1:0] DIV0_LO_DEFAULT = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_DIV_RUN = 2'd1,
    ST_DIV_FIX = 2'd2
  } hilo_state_t;

  function automatic logic [XLEN-1:0] neg_if(input logic neg, input logic [XLEN-1:0] v);
    return neg ? -v : v;
  endfunction

endpackage

// File: rtl/mips_cpu_divider.sv
// Iterative radix-2 restoring divider on unsigned magnitudes; one quotient bit
// per clock after the load edge. o_done flags the cycle whose edge retires the final step.
module mips_cpu_divider
  import mips_cpu_hilo_pkg::*;
#(
  parameter int unsigned ITERS = XLEN
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_start,
  input  logic [XLEN-1:0] i_dividend,
  input  logic [XLEN-1:0] i_divisor,
  output logic            o_busy,
  output logic            o_done,
  output logic [XLEN-1:0] o_quotient,
  output logic [XLEN-1:0] o_remainder
);

  localparam int unsigned CW = $clog2(ITERS + 1);

  logic [CW-1:0]   r_cnt;
  logic            r_run;
  logic [XLEN-1:0] r_q;
  logic [XLEN-1:0] r_d;
  logic [XLEN-1:0] r_rem;

  logic [XLEN:0]   w_shift;
  logic [XLEN:0]   w_diff;
  logic            w_fits;

  // Dividend bits shift out of r_q while quotient bits shift in behind them.
  assign w_shift = {r_rem, r_q[XLEN-1]};
  assign w_diff  = w_shift - {1'b0, r_d};
  assign w_fits  = ~w_diff[XLEN];

  assign o_busy      = r_run;
  assign o_done      = r_run && (r_cnt == CW'(ITERS - 1));
  assign o_quotient  = r_q;
  assign o_remainder = r_rem;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
      r_run <= 1'b0;
      r_q   <= '0;
      r_d   <= '0;
      r_rem <= '0;
    end else if (i_start) begin
      r_cnt <= '0;
      r_run <= 1'b1;
      r_q   <= i_dividend;
      r_d   <= i_divisor;
      r_rem <= '0;
    end else if (r_run) begin
      r_rem <= w_fits ? w_diff[XLEN-1:0] : w_shift[XLEN-1:0];
      r_q   <= {r_q[XLEN-2:0], w_fits};
      r_cnt <= r_cnt + CW'(1);
      if (o_done) r_run <= 1'b0;
    end
  end

endmodule

// File: rtl/mips_cpu_hilo_unit.sv
// MIPS HI/LO unit: single-cycle MULT/MULTU/MTHI/MTLO, 33-cycle DIV/DIVU.
// Define MIPS_CPU_HILO_MADD_EN to enable MADD/MADDU accumulation into {hi,lo}.
//
// state      | meaning
// ST_IDLE    | accepts start; single-cycle ops update hi/lo here
// ST_DIV_RUN | divider iterating on operand magnitudes
// ST_DIV_FIX | signs applied, quotient/remainder written to lo/hi
module mips_cpu_hilo_unit
  import mips_cpu_hilo_pkg::*;
#(
  parameter int unsigned     DIV_ITERS = XLEN,
  parameter logic [XLEN-1:0] DIV0_LO   = DIV0_LO_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [3:0]      op,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  hilo_state_t r_state;
  hilo_state_t w_state_nxt;

  logic [XLEN-1:0]   r_hi;
  logic [XLEN-1:0]   r_lo;
  logic              r_done;
  logic              r_neg_q;
  logic              r_neg_r;

  logic              w_accept;
  logic              w_div_op;
  logic              w_div_go;
  logic              w_mul_signed;
  logic              w_a_neg;
  logic              w_b_neg;
  logic [XLEN-1:0]   w_a_mag;
  logic [XLEN-1:0]   w_b_mag;
  logic [2*XLEN-1:0] w_mul_a;
  logic [2*XLEN-1:0] w_mul_b;
  logic [2*XLEN-1:0] w_prod;
  logic              w_div_busy;
  logic              w_div_last;
  logic [XLEN-1:0]   w_quo;
  logic [XLEN-1:0]   w_rem;

  assign w_accept     = start && (r_state == ST_IDLE);
  assign w_div_op     = (op == OP_DIV) || (op == OP_DIVU);
  assign w_div_go     = w_accept && w_div_op && (op_b != '0);
  assign w_mul_signed = (op == OP_MULT) || (op == OP_MADD);

  assign w_a_neg = (op == OP_DIV) && op_a[XLEN-1];
  assign w_b_neg = (op == OP_DIV) && op_b[XLEN-1];
  assign w_a_mag = neg_if(w_a_neg, op_a);
  assign w_b_mag = neg_if(w_b_neg, op_b);

  // Low 64 bits of the product of sign/zero-extended operands serve both MULT and MULTU.
  assign w_mul_a = {{XLEN{w_mul_signed & op_a[XLEN-1]}}, op_a};
  assign w_mul_b = {{XLEN{w_mul_signed & op_b[XLEN-1]}}, op_b};
  assign w_prod  = w_mul_a * w_mul_b;

`ifdef MIPS_CPU_HILO_MADD_EN
  logic [2*XLEN-1:0] w_acc;
  assign w_acc = {r_hi, r_lo} + w_prod;
`endif

  mips_cpu_divider #(
    .ITERS(DIV_ITERS)
  ) u_divider (
    .clk        (clk),
    .reset      (reset),
    .i_start    (w_div_go),
    .i_dividend (w_a_mag),
    .i_divisor  (w_b_mag),
    .o_busy     (w_div_busy),
    .o_done     (w_div_last),
    .o_quotient (w_quo),
    .o_remainder(w_rem)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:    if (w_div_go) w_state_nxt = ST_DIV_RUN;
      ST_DIV_RUN: if (w_div_last) w_state_nxt = ST_DIV_FIX;
      ST_DIV_FIX: w_state_nxt = ST_IDLE;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_hi    <= '0;
      r_lo    <= '0;
      r_done  <= 1'b0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_state == ST_DIV_FIX) begin
        r_lo   <= neg_if(r_neg_q, w_quo);
        r_hi   <= neg_if(r_neg_r, w_rem);
        r_done <= 1'b1;
      end else if (w_accept) begin
        case (op)
          OP_MULT, OP_MULTU: begin
            {r_hi, r_lo} <= w_prod;
            r_done       <= 1'b1;
          end
          OP_MTHI: begin
            r_hi   <= op_a;
            r_done <= 1'b1;
          end
          OP_MTLO: begin
            r_lo   <= op_a;
            r_done <= 1'b1;
          end
          OP_DIV, OP_DIVU: begin
            if (op_b == '0) begin
              r_hi   <= op_a;
              r_lo   <= DIV0_LO;
              r_done <= 1'b1;
            end else begin
              r_neg_q <= w_a_neg ^ w_b_neg;
              r_neg_r <= w_a_neg;
            end
          end
`ifdef MIPS_CPU_HILO_MADD_EN
          OP_MADD, OP_MADDU: begin
            {r_hi, r_lo} <= w_acc;
            r_done       <= 1'b1;
          end
`endif
          default: ;
        endcase
      end
    end
  end

  assign busy = (r_state != ST_IDLE) || w_div_busy;
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

// File: doc/mips_cpu_hilo_unit.md
Name: mips_cpu_hilo_unit

Overview:
- Multiply/divide unit with architectural HI/LO registers. Sits directly downstream of mips_cpu_register_file and consumes its read_data_1 (rs) and read_data_2 (rt) outputs.
- Executes MULT/MULTU/DIV/DIVU/MTHI/MTLO. Multiply and move complete single-cycle; divide is a multi-cycle iterative operation.
- Exposes hi/lo to the datapath for MFHI/MFLO, and busy so the control path can stall a dependent MFHI/MFLO.

Parameters:
- DIV_ITERS, 32, radix-2 divide iteration count; must equal the data width (only 32 is supported).
- DIV0_LO, 32'hFFFF_FFFF, LO value written on divide-by-zero.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high; clears all state
- start  input  1  one-cycle request; op/op_a/op_b are sampled on the same edge
- op  input  4  operation code (values in package)
- op_a  input  32  rs operand (from read_data_1)
- op_b  input  32  rt operand (from read_data_2)
- busy  output  1  divide in progress; new starts are ignored while high
- done  output  1  one-cycle pulse, high in the cycle after hi/lo update
- hi  output  32  HI register
- lo  output  32  LO register

Behaviour:
- Clocking and reset: one clock (clk). Reset is synchronous and active-high (reset). On reset: hi=0, lo=0, busy=0, done=0, state=IDLE, iteration counter=0.
- Reset mid-divide aborts the divide: no hi/lo update and no done pulse.
- Op codes: 0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MADD, 8 MADDU. Codes 9-15 and NOP are ignored: no update, no done.
- start is honoured only in IDLE. When busy=1, start is ignored with no side effect, including for MTHI/MTLO.
- MULT/MULTU:
  - On the sampling edge, {hi,lo} <= 64-bit product (signed or unsigned).
  - done=1 for the next cycle; busy stays 0.
- MTHI/MTLO:
  - On the sampling edge, hi<=op_a or lo<=op_a; the other register is unchanged.
  - done pulses.
- DIV/DIVU with op_b != 0:
  - Edge 0: latch operands and enter DIV_RUN. busy=1 from edge 0.
  - Edges 1..32: one restoring-division step per edge on magnitudes.
  - Edge 33 (DIV_FIX): apply signs, write lo=quotient and hi=remainder, return to IDLE. busy falls and done rises on the same edge.
  - Total latency is 33 cycles from start to result.
- Signed divide rules:
  - Quotient is negative iff sign(a)^sign(b).
  - Remainder takes the sign of the dividend.
  - Truncation is toward zero.
  - 0x8000_0000 / 0xFFFF_FFFF -> lo=0x8000_0000, hi=0.
- Divide-by-zero (op_b==0, signed or unsigned): single-cycle, hi<=op_a, lo<=DIV0_LO, done pulses, busy never rises.
- State machine:
  - IDLE -> DIV_RUN on an accepted divide with op_b!=0.
  - DIV_RUN -> DIV_FIX when the counter reaches DIV_ITERS.
  - DIV_FIX -> IDLE.
- hi/lo change only on the update edges defined above. During DIV_RUN they hold their previous values.

Optional Feature:
- Macro MIPS_CPU_HILO_MADD_EN.
- Defined: MADD/MADDU give {hi,lo} <= {hi,lo} + product (signed or unsigned). The sum wraps mod 2^64, is single-cycle, and pulses done.
- Undefined: codes 7/8 are treated as NOP (no update, no done). No accumulator adder is synthesised.

Decomposition:
- Package mips_cpu_hilo_pkg holds:
  - op code localparams
  - state encoding (IDLE, DIV_RUN, DIV_FIX)
  - DIV0_LO default
  - width constant 32
- Sub-module mips_cpu_divider: iterative unsigned magnitude divider with start/busy/done, quotient and remainder outputs.
- The top level handles sign conversion, the multiplier, MTHI/MTLO, MADD, and the HI/LO registers.

Test Plan:
- Reset then MULT 0xFFFF_FFFF x 0x0000_0002 -> next cycle hi=0xFFFF_FFFF, lo=0xFFFF_FFFE, done=1 for 1 cycle, busy=0.
- MULTU 0xFFFF_FFFF x 0x0000_0002 -> hi=0x0000_0001, lo=0xFFFF_FFFE.
- DIV -7 / 2 -> busy high 33 cycles; then lo=0xFFFF_FFFD (-3), hi=0xFFFF_FFFF (-1), done pulse coincident with busy falling. DIVU 100/7 -> lo=14, hi=2.
- DIV 0x8000_0000 / 0xFFFF_FFFF -> lo=0x8000_0000, hi=0. DIVU 5/0 -> next cycle hi=5, lo=0xFFFF_FFFF, busy never high.
- During a DIV, issue MTHI 0x1234 at cycle 10 -> ignored, hi unaffected until the divide result. Assert reset at cycle 20 -> hi=lo=0, busy=0, no done.
- MTHI 0, MTLO 0xFFFF_FFFF, then MADDU 1x1 -> with MIPS_CPU_HILO_MADD_EN: hi=1, lo=0. Without it: hi=0, lo=0xFFFF_FFFF, no done.
